// File: rtl/vend_txn_controller.sv
// vend_txn_controller: transaction sequencer between the coin acceptor and the
// vending state machine. Accumulates coin credit with saturation, latches a
// discounted price, checks funds, runs the dispense handshake, then pays out
// change or a refund.
// Optional feature: define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC
// idle cycles in COLLECT; without it COLLECT waits indefinitely.
module vend_txn_controller #(
    parameter int CREDIT_W    = 16,
    parameter int COIN_W      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_value,
    input  logic                item_req,
    input  logic [CREDIT_W-1:0] item_price,
    input  logic [CREDIT_W-1:0] discount,
    input  logic                cancel,
    input  logic                disp_ready,
    output logic                disp_valid,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                insufficient,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        CHECK    = 3'd2,
        DISPENSE = 3'd3,
        CHANGE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] eff_price_q, eff_price_d;
    logic                disp_valid_q, disp_valid_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic                insufficient_q, insufficient_d;
    logic                busy_q, busy_d;
    logic                timeout_hit;

`ifdef VEND_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    // Idle timer: runs only while waiting in COLLECT, any coin restarts it
    always_comb begin
        timer_d = '0;
        if (state_q == COLLECT && !coin_valid) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign timeout_hit = (timer_q == TIMER_LAST) && !coin_valid;
`else
    assign timeout_hit = 1'b0;
`endif

    // Add a coin to the credit, clamping at all-ones instead of wrapping
    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                    input logic [COIN_W-1:0]   b);
        logic [CREDIT_W:0] sum;
        sum = {1'b0, a} + (CREDIT_W + 1)'(b);
        return sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
    endfunction

    // Discount larger than the price makes the item free rather than negative
    function automatic logic [CREDIT_W-1:0] eff_price(input logic [CREDIT_W-1:0] price,
                                                      input logic [CREDIT_W-1:0] disc);
        return (price > disc) ? (price - disc) : '0;
    endfunction

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        eff_price_d    = eff_price_q;
        disp_valid_d   = disp_valid_q;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        insufficient_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin_valid) begin
                    credit_d = sat_add(credit_q, coin_value);
                    state_d  = COLLECT;
                end else if (item_req && credit_q == '0) begin
                    insufficient_d = 1'b1;
                end
            end
            COLLECT: begin
                // The coin lands in the same cycle as a request so CHECK sees it
                if (coin_valid) begin
                    credit_d = sat_add(credit_q, coin_value);
                end
                if (cancel) begin
                    state_d = CHANGE;
                end else if (item_req) begin
                    eff_price_d = eff_price(item_price, discount);
                    state_d     = CHECK;
                end else if (timeout_hit) begin
                    state_d = CHANGE;
                end
            end
            CHECK: begin
                if (credit_q >= eff_price_q) begin
                    disp_valid_d = 1'b1;
                    state_d      = DISPENSE;
                end else begin
                    insufficient_d = 1'b1;
                    state_d        = COLLECT;
                end
            end
            DISPENSE: begin
                // Credit was checked against eff_price, so this cannot underflow
                if (disp_ready) begin
                    credit_d     = credit_q - eff_price_q;
                    disp_valid_d = 1'b0;
                    state_d      = CHANGE;
                end
            end
            CHANGE: begin
                if (credit_q != '0) begin
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                end
                credit_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d      = IDLE;
                credit_d     = '0;
                disp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            eff_price_q    <= '0;
            disp_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            insufficient_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            timer_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            eff_price_q    <= eff_price_d;
            disp_valid_q   <= disp_valid_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            insufficient_q <= insufficient_d;
            busy_q         <= busy_d;
`ifdef VEND_TIMEOUT_EN
            timer_q        <= timer_d;
`endif
        end
    end

    assign disp_valid   = disp_valid_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign insufficient = insufficient_q;
    assign busy         = busy_q;
    assign credit       = credit_q;

endmodule
